// File: rtl/dmx_universe_tx.sv
// DMX512 transmitter: pan/tilt channel writes into a slot buffer, serialised as 250 kbaud 8N2 frames.
// Optional macro DMX_FRAME_LATCH_EN stages writes and commits them at frame start for coherent frames.
module dmx_universe_tx #(
    parameter int CLK_HZ     = 65_000_000,
    parameter int NUM_SLOTS  = 512,
    parameter int BREAK_BITS = 25,
    parameter int MAB_BITS   = 3,
    parameter int IDLE_BITS  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] pan,
    input  logic [8:0] pan_addr,
    input  logic [7:0] tilt,
    input  logic [8:0] tilt_addr,
    input  logic       ready,
    output logic       dmx_out,
    output logic       tx_en,
    output logic       frame_done
);
    localparam int BIT_CYCLES = CLK_HZ / 250_000;
    localparam int BCW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int DEPTH      = 1 << AW;

    typedef enum logic [1:0] {IDLE, BREAK, MAB, SLOT} state_t;

    state_t         state, state_nxt;
    logic [BCW-1:0] bit_cnt;
    logic [7:0]     bit_idx, bit_idx_nxt;
    logic [9:0]     slot_cnt, slot_nxt;
    logic [7:0]     slot_byte;
    logic           wrap, load_byte, load_zero, done_nxt, done_p0, line_nxt;
    logic [7:0]     slot_buf [DEPTH];

    logic           wr_en;
    logic [7:0]     wr_pan, wr_tilt;
    logic [8:0]     wr_pan_addr, wr_tilt_addr;

    assign wrap = (bit_cnt == BCW'(BIT_CYCLES - 1));

`ifdef DMX_FRAME_LATCH_EN
    logic       commit, pend_vld;
    logic [7:0] pend_pan, pend_tilt;
    logic [8:0] pend_pan_addr, pend_tilt_addr;

    assign commit = wrap && (state == IDLE) && (bit_idx == 8'(IDLE_BITS - 1)) && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld <= 1'b0;
        end else if (commit) begin
            pend_vld <= 1'b0;
        end else if (ready) begin
            pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ready) begin
            pend_pan       <= pan;
            pend_pan_addr  <= pan_addr;
            pend_tilt      <= tilt;
            pend_tilt_addr <= tilt_addr;
        end
    end

    // A strobe coinciding with the commit is the newest pair, so it goes straight in.
    always_comb begin
        wr_en        = commit && (ready || pend_vld);
        wr_pan       = ready ? pan       : pend_pan;
        wr_pan_addr  = ready ? pan_addr  : pend_pan_addr;
        wr_tilt      = ready ? tilt      : pend_tilt;
        wr_tilt_addr = ready ? tilt_addr : pend_tilt_addr;
    end
`else
    always_comb begin
        wr_en        = ready;
        wr_pan       = pan;
        wr_pan_addr  = pan_addr;
        wr_tilt      = tilt;
        wr_tilt_addr = tilt_addr;
    end
`endif

    // Tilt is written after pan so it wins on a shared address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) slot_buf[i] <= 8'h00;
        end else if (wr_en) begin
            if (32'(wr_pan_addr) < NUM_SLOTS)  slot_buf[wr_pan_addr[AW-1:0]]  <= wr_pan;
            if (32'(wr_tilt_addr) < NUM_SLOTS) slot_buf[wr_tilt_addr[AW-1:0]] <= wr_tilt;
        end
    end

    always_ff @(posedge clk) begin
        if (load_zero) begin
            slot_byte <= 8'h00;
        end else if (load_byte) begin
            slot_byte <= slot_buf[slot_cnt[AW-1:0]];
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        slot_nxt    = slot_cnt;
        load_byte   = 1'b0;
        load_zero   = 1'b0;
        done_nxt    = 1'b0;
        line_nxt    = 1'b1;
        if (state == BREAK) begin
            line_nxt = 1'b0;
        end else if (state == SLOT) begin
            if (bit_idx == 8'd0) line_nxt = 1'b0;
            else if (bit_idx <= 8'd8) line_nxt = slot_byte[3'(bit_idx - 8'd1)];
        end
        if (wrap) begin
            bit_idx_nxt = bit_idx + 8'd1;
            case (state)
                IDLE: if (bit_idx == 8'(IDLE_BITS - 1)) begin
                    bit_idx_nxt = '0;
                    if (enable) state_nxt = BREAK;
                end
                BREAK: if (bit_idx == 8'(BREAK_BITS - 1)) begin
                    bit_idx_nxt = '0;
                    state_nxt   = MAB;
                end
                MAB: if (bit_idx == 8'(MAB_BITS - 1)) begin
                    bit_idx_nxt = '0;
                    state_nxt   = SLOT;
                    slot_nxt    = '0;
                    load_zero   = 1'b1;
                end
                SLOT: if (bit_idx == 8'd10) begin
                    bit_idx_nxt = '0;
                    if (slot_cnt == 10'(NUM_SLOTS)) begin
                        state_nxt = IDLE;
                        slot_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        slot_nxt  = slot_cnt + 10'd1;
                        load_byte = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and frame_done are registered from the current state; frame_done lags one more
    // cycle so it lands after the final stop bit has been on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            slot_cnt   <= '0;
            dmx_out    <= 1'b1;
            tx_en      <= 1'b0;
            done_p0    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= wrap ? '0 : bit_cnt + 1'b1;
            bit_idx    <= bit_idx_nxt;
            slot_cnt   <= slot_nxt;
            dmx_out    <= line_nxt;
            tx_en      <= 1'b1;
            done_p0    <= done_nxt;
            frame_done <= done_p0;
        end
    end
endmodule
